pwm_deadtime_ctrl: RTL and testbench

Sequencer for one complementary half-bridge leg. It takes a single raw PWM command and drives the high-side and low-side gate signals. Every switch-over passes through a dead band timed by an internal dead-time counter, so both gates can never be on together. It sits between the PWM carrier/compare stage and the gate-driver pins, one instance per leg.

---
 rtl/pwm_deadtime_ctrl_pkg.sv | 20 ++
 rtl/pwm_deadtime_counter.sv | 38 +++
 rtl/pwm_deadtime_ctrl.sv | 96 +++++++++
 tb/tb_pwm_deadtime_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pwm_deadtime_ctrl_pkg.sv
// Shared definitions for the half-bridge dead-time sequencer:
// state encoding, default counter width and a dead-band state test.
package pwm_deadtime_ctrl_pkg;

  localparam int DT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HS_ON  = 3'd1,
    ST_DT_H2L = 3'd2,
    ST_LS_ON  = 3'd3,
    ST_DT_L2H = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  function automatic logic is_dead(input state_e s);
    return (s == ST_DT_H2L) || (s == ST_DT_L2H);
  endfunction

endpackage

// File: rtl/pwm_deadtime_counter.sv
// Dead-band timer: counts up from 0 while enabled, flags the last cycle of a
// band of max(dt, 1) cycles. Clear has priority over count enable.
module pwm_deadtime_counter #(
  parameter int DT_W = 16
) (
  input  logic            clk_100,
  input  logic            RST,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [DT_W-1:0] dt_i,
  output logic [DT_W-1:0] cnt_o,
  output logic            term_o
);

  logic [DT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + DT_W'(1);
    end
  end

  always_ff @(posedge clk_100) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero setting still yields a single both-off cycle.
  assign term_o = (dt_i == '0) || (cnt_q == (dt_i - DT_W'(1)));
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pwm_deadtime_ctrl.sv
// Complementary half-bridge leg sequencer: every gate hand-over passes through
// a latched dead band; all outputs are registered alongside the state.
module pwm_deadtime_ctrl
  import pwm_deadtime_ctrl_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk_100,
  input  logic            RST,
  input  logic            enable,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] PWM_DEAD_TIME,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            PWM_H,
  output logic            PWM_L,
  output logic            dead_active,
  output logic            fault_flag,
  output logic [2:0]      state
);

  state_e          state_q, state_d;
  logic [DT_W-1:0] dt_lat_q, dt_lat_d;
  logic [DT_W-1:0] dt_cnt;
  logic            pwm_h_q, pwm_l_q, dead_q, fault_q;
  logic            term, band_stay, band_entry, cnt_clr;

  pwm_deadtime_counter #(.DT_W(DT_W)) u_cnt (
    .clk_100 (clk_100),
    .RST     (RST),
    .clr_i   (cnt_clr),
    .en_i    (band_stay),
    .dt_i    (dt_lat_q),
    .cnt_o   (dt_cnt),
    .term_o  (term)
  );

  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr) state_d = ST_IDLE;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = pwm_in ? ST_DT_L2H : ST_DT_H2L;
        ST_HS_ON:  if (!pwm_in) state_d = ST_DT_H2L;
        ST_LS_ON:  if (pwm_in) state_d = ST_DT_L2H;
        ST_DT_H2L: begin
          if (pwm_in)    state_d = ST_HS_ON;
          else if (term) state_d = ST_LS_ON;
        end
        ST_DT_L2H: begin
          if (!pwm_in)   state_d = ST_LS_ON;
          else if (term) state_d = ST_HS_ON;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // The counter only advances while a band continues; any other move restarts it.
  always_comb begin
    band_stay  = is_dead(state_q) && (state_d == state_q);
    band_entry = is_dead(state_d) && !band_stay;
    dt_lat_d   = band_entry ? PWM_DEAD_TIME : dt_lat_q;
    cnt_clr    = !band_stay && (dt_cnt != '0);
  end

  always_ff @(posedge clk_100) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      dt_lat_q <= '0;
      pwm_h_q  <= 1'b0;
      pwm_l_q  <= 1'b0;
      dead_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_lat_q <= dt_lat_d;
      pwm_h_q  <= (state_d == ST_HS_ON);
      pwm_l_q  <= (state_d == ST_LS_ON);
      dead_q   <= is_dead(state_d);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign PWM_H       = pwm_h_q;
  assign PWM_L       = pwm_l_q;
  assign dead_active = dead_q;
  assign fault_flag  = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pwm_deadtime_ctrl.sv
// Bench for pwm_deadtime_ctrl: directed scenarios then random pwm/dt/fault
// traffic, checked against a countdown-style model through a scoreboard queue.
module tb_pwm_deadtime_ctrl;

  logic        clk_100 = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] PWM_DEAD_TIME = '0;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic        PWM_H, PWM_L, dead_active, fault_flag;
  logic [2:0]  state;

  pwm_deadtime_ctrl #(.DT_W(16)) dut (
    .clk_100       (clk_100),
    .RST           (RST),
    .enable        (enable),
    .pwm_in        (pwm_in),
    .PWM_DEAD_TIME (PWM_DEAD_TIME),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .PWM_H         (PWM_H),
    .PWM_L         (PWM_L),
    .dead_active   (dead_active),
    .fault_flag    (fault_flag),
    .state         (state)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic        h;
    logic        l;
    logic        dead;
    logic        flt;
    logic [2:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: which gate is on, or a dead band counting down remaining cycles.
  localparam int M_IDLE = 0, M_HIGH = 1, M_LOW = 2, M_DEAD = 3, M_FAULT = 4;
  int m_mode = M_IDLE;
  int m_tgt  = 0;
  int m_lat  = 0;
  int m_left = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void start_band(input int tgt, input logic [15:0] dt);
    m_mode = M_DEAD;
    m_tgt  = tgt;
    m_lat  = (dt == 0) ? 1 : int'(dt);
    m_left = m_lat;
  endfunction

  task automatic step(input logic rst, input logic en, input logic pwm,
                      input logic [15:0] dt, input logic flt, input logic clr);
    exp_t e;
    @(negedge clk_100);
    RST = rst; enable = en; pwm_in = pwm; PWM_DEAD_TIME = dt;
    fault = flt; fault_clr = clr;
    if (rst) m_mode = M_IDLE;
    else if (flt) m_mode = M_FAULT;
    else if (m_mode == M_FAULT) begin
      if (clr) m_mode = M_IDLE;
    end else if (!en) m_mode = M_IDLE;
    else begin
      case (m_mode)
        M_IDLE: start_band(pwm ? 1 : 0, dt);
        M_HIGH: if (!pwm) start_band(0, dt);
        M_LOW:  if (pwm) start_band(1, dt);
        default: begin
          if (int'(pwm) != m_tgt) m_mode = pwm ? M_HIGH : M_LOW;
          else begin
            m_left--;
            if (m_left == 0) m_mode = (m_tgt == 1) ? M_HIGH : M_LOW;
          end
        end
      endcase
    end
    e.h    = (m_mode == M_HIGH);
    e.l    = (m_mode == M_LOW);
    e.dead = (m_mode == M_DEAD);
    e.flt  = (m_mode == M_FAULT);
    case (m_mode)
      M_HIGH:  e.st = 3'd1;
      M_LOW:   e.st = 3'd3;
      M_DEAD:  e.st = (m_tgt == 1) ? 3'd4 : 3'd2;
      M_FAULT: e.st = 3'd5;
      default: e.st = 3'd0;
    endcase
    e.cnt = (m_mode == M_DEAD) ? 16'(m_lat - m_left) : 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic en, input logic pwm, input logic [15:0] dt);
    for (int i = 0; i < n; i++) step(1'b0, en, pwm, dt, 1'b0, 1'b0);
  endtask

  // Monitor: one expected record per clock edge once stimulus has started.
  always @(posedge clk_100) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("PWM_H", 16'(PWM_H), 16'(e.h));
      chk("PWM_L", 16'(PWM_L), 16'(e.l));
      chk("dead_active", 16'(dead_active), 16'(e.dead));
      chk("fault_flag", 16'(fault_flag), 16'(e.flt));
      chk("state", 16'(state), 16'(e.st));
      chk("dt_count", dut.dt_cnt, e.cnt);
      chk("never_both_on", 16'(PWM_H & PWM_L), 16'd0);
    end
  end

  initial begin
    logic en_r, pwm_r, flt_r, clr_r, rst_r;
    logic [15:0] dt_r;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    run(8, 1'b1, 1'b1, 16'd4);
    run(6, 1'b1, 1'b0, 16'd3);
    run(3, 1'b1, 1'b1, 16'd0);
    run(3, 1'b1, 1'b0, 16'd0);
    run(1, 1'b1, 1'b1, 16'd2);
    run(3, 1'b1, 1'b1, 16'd10);
    run(13, 1'b1, 1'b0, 16'd10);
    run(5, 1'b1, 1'b1, 16'd3);
    run(2, 1'b1, 1'b0, 16'd8);
    run(4, 1'b1, 1'b1, 16'd8);
    run(4, 1'b1, 1'b0, 16'd1);
    step(1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 1'b1);
    run(6, 1'b1, 1'b0, 16'd2);
    run(2, 1'b1, 1'b1, 16'd6);
    run(1, 1'b0, 1'b1, 16'd6);
    run(8, 1'b1, 1'b1, 16'd6);
    run(2, 1'b1, 1'b0, 16'd5);
    step(1'b1, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0);
    run(8, 1'b1, 1'b0, 16'd5);

    en_r = 1'b1; pwm_r = 1'b0; flt_r = 1'b0; dt_r = 16'd2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(5, 0) == 0) pwm_r = ~pwm_r;
      if ($urandom_range(15, 0) == 0) dt_r = 16'($urandom_range(5, 0));
      if ($urandom_range(150, 0) == 0) en_r = ~en_r;
      if (flt_r) flt_r = ($urandom_range(2, 0) != 0);
      else flt_r = ($urandom_range(200, 0) == 0);
      clr_r = ($urandom_range(9, 0) == 0);
      rst_r = ($urandom_range(499, 0) == 0);
      step(rst_r, en_r, pwm_r, dt_r, flt_r, clr_r);
    end

    repeat (3) @(negedge clk_100);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
